// File: rtl/mac_round_sat_if.sv
// Term/result bus for the rounding, saturating MAC.
// The master drives the operands and controls; the slave returns the scaled result.
interface mac_round_sat_if #(
  parameter int unsigned IN_WIDTH    = 16,
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned SHIFT_WIDTH = 6
);
  logic                   enable;
  logic                   clear;
  logic                   dump;
  logic [IN_WIDTH-1:0]    x;
  logic [IN_WIDTH-1:0]    y;
  logic [SHIFT_WIDTH-1:0] shift;
  logic [OUT_WIDTH-1:0]   z;
  logic                   z_valid;
  logic                   sat;

  modport master (
    output enable, clear, dump, x, y, shift,
    input  z, z_valid, sat
  );

  modport slave (
    input  enable, clear, dump, x, y, shift,
    output z, z_valid, sat
  );
endinterface

// File: rtl/mac_round_sat.sv
// Three-stage signed multiply-accumulate with run-time shift, round-half-up and
// saturation to OUT_WIDTH; back-to-back sums need no idle cycle.
module mac_round_sat #(
  parameter int unsigned IN_WIDTH    = 16,
  parameter int unsigned ACC_WIDTH   = 40,
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned SHIFT_WIDTH = 6,
  parameter int unsigned MAX_SHIFT   = 24
) (
  input logic            clk,
  input logic            rst_n,
  mac_round_sat_if.slave bus
);
  localparam int unsigned PW = 2 * IN_WIDTH;
  localparam int unsigned EW = ACC_WIDTH + 1;
  localparam logic [SHIFT_WIDTH-1:0] SHIFT_CAP = SHIFT_WIDTH'(MAX_SHIFT);
  localparam logic signed [EW-1:0] MAX_POS =
    {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_NEG =
    {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [PW-1:0]        x_ext;
  logic signed [PW-1:0]        y_ext;
  logic signed [PW-1:0]        product;
  logic                        p_en;
  logic                        p_clr;
  logic                        p_dmp;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [ACC_WIDTH-1:0] a_sum;
  logic                        a_dmp;
  logic [SHIFT_WIDTH-1:0]      s;
  logic signed [EW-1:0]        sum_ext;
  logic signed [EW-1:0]        half;
  logic signed [EW-1:0]        rounded;
  logic signed [EW-1:0]        scaled;
  logic                        sat_hi;
  logic                        sat_lo;
  logic [OUT_WIDTH-1:0]        z_next;

  assign x_ext = PW'($signed(bus.x));
  assign y_ext = PW'($signed(bus.y));

  // Stage 1: product and qualified controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product <= '0;
      p_en    <= 1'b0;
      p_clr   <= 1'b0;
      p_dmp   <= 1'b0;
    end else begin
      product <= x_ext * y_ext;
      p_en    <= bus.enable;
      p_clr   <= bus.enable & bus.clear;
      p_dmp   <= bus.enable & bus.dump;
    end
  end

  // Clearing term restarts the sum from its own product, so back-to-back sums stay separate
  always_comb begin
    prod_ext = ACC_WIDTH'(product);
    acc_next = (p_clr ? '0 : acc) + prod_ext;
  end

  // Stage 2: wrapping accumulator plus a snapshot for the output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      a_sum <= '0;
      a_dmp <= 1'b0;
    end else begin
      if (p_en) begin
        acc <= acc_next;
      end
      a_sum <= p_en ? acc_next : acc;
      a_dmp <= p_dmp;
    end
  end

  // One extra bit keeps the rounding add from overflowing before the shift
  always_comb begin
    s       = (bus.shift > SHIFT_CAP) ? SHIFT_CAP : bus.shift;
    sum_ext = EW'(a_sum);
    half    = '0;
    if (s != '0) begin
      half = EW'(1) << (s - SHIFT_WIDTH'(1));
    end
    rounded = sum_ext + half;
    scaled  = rounded >>> s;
    sat_hi  = scaled > MAX_POS;
    sat_lo  = scaled < MIN_NEG;
    z_next  = scaled[OUT_WIDTH-1:0];
    if (sat_hi) begin
      z_next = MAX_POS[OUT_WIDTH-1:0];
    end else if (sat_lo) begin
      z_next = MIN_NEG[OUT_WIDTH-1:0];
    end
  end

  // Stage 3: result and sat held between dumps, valid pulses once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.z       <= '0;
      bus.sat     <= 1'b0;
      bus.z_valid <= 1'b0;
    end else begin
      bus.z_valid <= a_dmp;
      if (a_dmp) begin
        bus.z   <= z_next;
        bus.sat <= sat_hi | sat_lo;
      end
    end
  end
endmodule

// File: tb/tb_mac_round_sat.sv
// Directed bench for mac_round_sat: single-term vector table plus multi-term,
// back-to-back, enable-gap and mid-sum reset sequences.
module tb_mac_round_sat;
  localparam int unsigned IN_WIDTH    = 16;
  localparam int unsigned ACC_WIDTH   = 40;
  localparam int unsigned OUT_WIDTH   = 16;
  localparam int unsigned SHIFT_WIDTH = 6;
  localparam int unsigned MAX_SHIFT   = 24;

  typedef struct {
    int x;
    int y;
    int sh;
    int ez;
    bit es;
  } vec_t;

  typedef struct {
    int zv;
    bit sv;
    int cyc;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   last_dump_cyc = 0;
  res_t q[$];
  vec_t vecs[16];

  mac_round_sat_if #(
    .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH)
  ) bus ();

  mac_round_sat #(
    .IN_WIDTH(IN_WIDTH), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH), .MAX_SHIFT(MAX_SHIFT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every valid cycle shortly after the edge
  always @(posedge clk) begin
    #1;
    if (bus.z_valid === 1'b1) begin
      q.push_back('{int'($signed(bus.z)), bus.sat, cyc});
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic term(input int xv, input int yv, input bit clr, input bit dmp, input int sh);
    @(negedge clk);
    bus.enable = 1'b1;
    bus.clear  = clr;
    bus.dump   = dmp;
    bus.x      = 16'(xv);
    bus.y      = 16'(yv);
    bus.shift  = 6'(sh);
    if (dmp) last_dump_cyc = cyc;
  endtask

  // Idle cycle with clear/dump asserted but no enable: must be ignored
  task automatic gap();
    @(negedge clk);
    bus.enable = 1'b0;
    bus.clear  = 1'b1;
    bus.dump   = 1'b1;
    bus.x      = 16'h7fff;
    bus.y      = 16'h7fff;
  endtask

  task automatic stop_terms();
    @(negedge clk);
    bus.enable = 1'b0;
    bus.clear  = 1'b0;
    bus.dump   = 1'b0;
  endtask

  task automatic expect_result(input string name, input int ez, input bit es, input bit chk_lat);
    int   n;
    res_t r;
    n = 0;
    while (q.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid_seen"}, int'(q.size() > 0), 1);
    if (q.size() > 0) begin
      r = q.pop_front();
      check({name, "_z"}, r.zv, ez);
      check({name, "_sat"}, int'(r.sv), int'(es));
      if (chk_lat) check({name, "_latency"}, r.cyc - last_dump_cyc, 3);
    end
  endtask

  task automatic expect_quiet(input string name);
    repeat (4) @(negedge clk);
    check({name, "_no_extra_valid"}, q.size(), 0);
    q.delete();
  endtask

  initial begin
    vecs[0]  = '{3, 4, 0, 12, 1'b0};
    vecs[1]  = '{3, 1, 1, 2, 1'b0};
    vecs[2]  = '{-3, 1, 1, -1, 1'b0};
    vecs[3]  = '{-5, 1, 1, -2, 1'b0};
    vecs[4]  = '{7, 1, 2, 2, 1'b0};
    vecs[5]  = '{-7, 1, 2, -2, 1'b0};
    vecs[6]  = '{-32768, -32768, 0, 32767, 1'b1};
    vecs[7]  = '{-32768, -32768, 15, 32767, 1'b1};
    vecs[8]  = '{-32768, -32768, 16, 16384, 1'b0};
    vecs[9]  = '{-32768, 1, 0, -32768, 1'b0};
    vecs[10] = '{32767, 1, 0, 32767, 1'b0};
    vecs[11] = '{-32768, -1, 0, 32767, 1'b1};
    vecs[12] = '{300, 300, 40, 0, 1'b0};
    vecs[13] = '{100, -100, 0, -10000, 1'b0};
    vecs[14] = '{-1, 1, 1, 0, 1'b0};
    vecs[15] = '{-32768, -32768, 25, 64, 1'b0};

    bus.enable = 1'b0;
    bus.clear  = 1'b0;
    bus.dump   = 1'b0;
    bus.x      = '0;
    bus.y      = '0;
    bus.shift  = '0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_z", int'(bus.z), 0);
    check("reset_z_valid", int'(bus.z_valid), 0);
    check("reset_sat", int'(bus.sat), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      term(vecs[i].x, vecs[i].y, 1'b1, 1'b1, vecs[i].sh);
      stop_terms();
      expect_result($sformatf("vec%0d", i), vecs[i].ez, vecs[i].es, 1'b1);
      expect_quiet($sformatf("vec%0d", i));
    end

    for (int k = 0; k < 8; k++) term(1000, 1000, k == 0, k == 7, 8);
    stop_terms();
    expect_result("sum8_sh8", 31250, 1'b0, 1'b1);
    expect_quiet("sum8_sh8");
    for (int k = 0; k < 8; k++) term(1000, 1000, k == 0, k == 7, 3);
    stop_terms();
    expect_result("sum8_sh3", 32767, 1'b1, 1'b1);
    expect_quiet("sum8_sh3");

    for (int k = 0; k < 5; k++) term(2, 2, k == 0, k == 4, 0);
    for (int k = 0; k < 3; k++) term(1, 1, k == 0, k == 2, 0);
    stop_terms();
    expect_result("b2b_a", 20, 1'b0, 1'b0);
    expect_result("b2b_b", 3, 1'b0, 1'b1);
    expect_quiet("b2b");

    for (int k = 0; k < 4; k++) term(-32768, 32767, k == 0, k == 3, 40);
    stop_terms();
    expect_result("neg_clamp", -256, 1'b0, 1'b1);
    expect_quiet("neg_clamp");
    for (int k = 0; k < 4; k++) term(-32768, 32767, k == 0, k == 3, 0);
    stop_terms();
    expect_result("neg_sat", -32768, 1'b1, 1'b1);
    expect_quiet("neg_sat");

    term(10, 10, 1'b1, 1'b0, 0);
    gap();
    gap();
    term(10, 10, 1'b0, 1'b0, 0);
    gap();
    term(10, 10, 1'b0, 1'b1, 0);
    stop_terms();
    expect_result("enable_gaps", 300, 1'b0, 1'b1);
    expect_quiet("enable_gaps");

    term(7, 7, 1'b1, 1'b1, 0);
    @(negedge clk);
    bus.enable = 1'b0;
    bus.clear  = 1'b0;
    bus.dump   = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("reset_mid_no_valid", q.size(), 0);
    check("reset_mid_z", int'(bus.z), 0);
    check("reset_mid_sat", int'(bus.sat), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
